// File: rtl/vga_out_stage_if.sv
// Video/audio bundle between the demo generator and the pin-side output stage.
// master: generator side (drives colour, syncs, audio, mode; receives pixel_en and pin outputs).
// slave:  output stage side (receives generator signals, drives pixel_en, uo_out, audio_pwm).
interface vga_out_stage_if #(
  parameter int IN_BITS    = 4,
  parameter int AUDIO_BITS = 8
) ();
  logic [3*IN_BITS-1:0]  rgb_in;     // {r,g,b}, MSB-first per channel
  logic                  active_in;  // 1 = active video pixel
  logic                  hsync_in;   // raw hsync, active high
  logic                  vsync_in;   // raw vsync, active high
  logic [AUDIO_BITS-1:0] audio_in;   // unsigned audio sample
  logic [1:0]            mode;       // bit0 dither enable, bit1 invert syncs on pins
  logic                  pixel_en;   // pixel strobe back to the generator
  logic [7:0]            uo_out;     // {hsync,b0,g0,r0,vsync,b1,g1,r1}
  logic                  audio_pwm;  // sigma-delta audio bit

  modport master (
    output rgb_in, active_in, hsync_in, vsync_in, audio_in, mode,
    input  pixel_en, uo_out, audio_pwm
  );

  modport slave (
    input  rgb_in, active_in, hsync_in, vsync_in, audio_in, mode,
    output pixel_en, uo_out, audio_pwm
  );
endinterface

// File: rtl/vga_out_stage.sv
// Pin-side VGA output stage: pixel-clock enable, colour depth reduction with optional
// 4x4 ordered dither, blanking, sync polarity, TinyVGA pin packing and sigma-delta audio.
// Ports: clk, reset (sync, active-high), bus (vga_out_stage_if.slave). All outputs registered;
// video is sampled and uo_out updated only on pixel_en edges, audio runs every clock.
module vga_out_stage #(
  parameter int IN_BITS    = 4,
  parameter int OUT_BITS   = 2,
  parameter int DIV_LOG2   = 1,
  parameter int AUDIO_BITS = 8
) (
  input  logic           clk,
  input  logic           reset,
  vga_out_stage_if.slave bus
);

  localparam int D = IN_BITS - OUT_BITS;  // bits dropped per channel

  logic                  pixel_en_q;
  logic [1:0]            pos_x;
  logic [1:0]            pos_y;
  logic                  prev_active;
  logic [7:0]            uo_q;
  logic [7:0]            uo_nxt;
  logic [AUDIO_BITS-1:0] audio_acc;
  logic [AUDIO_BITS:0]   audio_sum;
  logic                  audio_pwm_q;

  // ---------------------------------------------------------------- pixel enable
  generate
    if (DIV_LOG2 == 0) begin : g_div_none
      always_ff @(posedge clk) begin
        if (reset) pixel_en_q <= 1'b0;
        else       pixel_en_q <= 1'b1;
      end
    end else begin : g_div
      logic [DIV_LOG2-1:0] div_cnt;
      // Strobe is registered from the all-ones count, so it lands one clock after it.
      always_ff @(posedge clk) begin
        if (reset) begin
          div_cnt    <= '0;
          pixel_en_q <= 1'b0;
        end else begin
          div_cnt    <= div_cnt + DIV_LOG2'(1);
          pixel_en_q <= &div_cnt;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- colour reduction
  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] v;
    case ({y, x})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
      4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  // With D == 0 the fraction mask is empty, so the increment can never fire.
  function automatic logic [OUT_BITS-1:0] reduce(input logic [IN_BITS-1:0] c,
                                                 input logic [3:0]         bv,
                                                 input logic               dith);
    logic [OUT_BITS-1:0] q;
    logic [IN_BITS-1:0]  f;
    logic [IN_BITS-1:0]  t;
    logic                inc;
    logic [OUT_BITS:0]   sum;
    q   = OUT_BITS'(c >> D);
    f   = c & IN_BITS'((1 << D) - 1);
    t   = IN_BITS'(bv >> (4 - D));
    inc = dith && (f > t);
    sum = {1'b0, q} + {{OUT_BITS{1'b0}}, inc};
    if (sum[OUT_BITS]) return '1;  // saturate at full scale
    return sum[OUT_BITS-1:0];
  endfunction

  always_comb begin
    logic [3:0]          bv;
    logic [OUT_BITS-1:0] r_v, g_v, b_v;
    logic                hs, vs;
    bv  = bayer(pos_y, pos_x);
    r_v = reduce(bus.rgb_in[3*IN_BITS-1 -: IN_BITS], bv, bus.mode[0]);
    g_v = reduce(bus.rgb_in[2*IN_BITS-1 -: IN_BITS], bv, bus.mode[0]);
    b_v = reduce(bus.rgb_in[IN_BITS-1:0],            bv, bus.mode[0]);
    if (!bus.active_in) begin
      r_v = '0;
      g_v = '0;
      b_v = '0;
    end
    hs = bus.hsync_in ^ bus.mode[1];
    vs = bus.vsync_in ^ bus.mode[1];
    // Top bit goes to the *1 pins, bit 0 to the *0 pins; a 1-bit channel drives both.
    uo_nxt = {hs, b_v[0], g_v[0], r_v[0], vs,
              b_v[OUT_BITS-1], g_v[OUT_BITS-1], r_v[OUT_BITS-1]};
  end

  // ---------------------------------------------------------------- video registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x       <= 2'd0;
      pos_y       <= 2'd0;
      prev_active <= 1'b0;
      uo_q        <= 8'h00;
    end else if (pixel_en_q) begin
      pos_x <= bus.active_in ? pos_x + 2'd1 : 2'd0;
      // Raw vsync (not the pin polarity) restarts the dither rows and beats the line step.
      if (bus.vsync_in)
        pos_y <= 2'd0;
      else if (prev_active && !bus.active_in)
        pos_y <= pos_y + 2'd1;
      prev_active <= bus.active_in;
      uo_q        <= uo_nxt;
    end
  end

  // ---------------------------------------------------------------- audio
  // The carry out of the accumulator add is the output bit; only the low bits are kept.
  assign audio_sum = {1'b0, audio_acc} + {1'b0, bus.audio_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_acc   <= '0;
      audio_pwm_q <= 1'b0;
    end else begin
      audio_acc   <= audio_sum[AUDIO_BITS-1:0];
      audio_pwm_q <= audio_sum[AUDIO_BITS];
    end
  end

  assign bus.pixel_en  = pixel_en_q;
  assign bus.uo_out    = uo_q;
  assign bus.audio_pwm = audio_pwm_q;

endmodule

// File: tb/tb_vga_out_stage.sv
module tb_vga_out_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_out_stage_if #(.IN_BITS(4), .AUDIO_BITS(8)) bus ();

  vga_out_stage #(.IN_BITS(4), .OUT_BITS(2), .DIV_LOG2(1), .AUDIO_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ph;    // edges since reset release
  bit         m_pe;
  int         m_x, m_y;
  bit         m_pact;
  logic [7:0] m_uo;
  int         m_acc;
  bit         m_pwm;
  int         bayer_tbl[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

  function automatic int chan(int c, int x, int y, bit dith);
    int q, f, t, v;
    q = c / 4;
    f = c % 4;
    t = bayer_tbl[y * 4 + x] / 4;
    v = q + ((dith && f > t) ? 1 : 0);
    if (v > 3) v = 3;
    return v;
  endfunction

  function automatic logic [7:0] pins(int r, int g, int b, bit hs, bit vs);
    logic [1:0] rr, gg, bb;
    rr = r[1:0];
    gg = g[1:0];
    bb = b[1:0];
    return {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    bit         pe_now, rst_now, act, hs, vs;
    logic [11:0] rgb;
    logic [1:0]  md;
    logic [7:0]  au;
    pe_now  = m_pe;
    rst_now = reset;
    act     = bus.active_in;
    hs      = bus.hsync_in;
    vs      = bus.vsync_in;
    rgb     = bus.rgb_in;
    md      = bus.mode;
    au      = bus.audio_in;
    @(posedge clk);
    if (rst_now) begin
      m_ph = 0; m_pe = 0; m_x = 0; m_y = 0; m_pact = 0;
      m_uo = 8'h00; m_acc = 0; m_pwm = 0;
    end else begin
      m_ph++;
      m_pe = (m_ph % 2 == 0);
      if (pe_now) begin
        if (act)
          m_uo = pins(chan(int'(rgb[11:8]), m_x, m_y, md[0]),
                      chan(int'(rgb[7:4]),  m_x, m_y, md[0]),
                      chan(int'(rgb[3:0]),  m_x, m_y, md[0]),
                      hs ^ md[1], vs ^ md[1]);
        else
          m_uo = pins(0, 0, 0, hs ^ md[1], vs ^ md[1]);
        if (vs) m_y = 0;
        else if (m_pact && !act) m_y = (m_y + 1) % 4;
        m_x = act ? (m_x + 1) % 4 : 0;
        m_pact = act;
      end
      m_acc += int'(au);
      m_pwm = (m_acc >= 256);
      m_acc = m_acc % 256;
    end
    #1;
  endtask

  // Run clocks until one enabled edge has consumed the current inputs.
  task automatic pixel();
    bit done;
    done = 0;
    for (int i = 0; i < 4 && !done; i++) begin
      done = m_pe;
      step();
    end
    if (!done) begin
      errors++;
      $display("FAIL pixel_timeout no pixel_en edge within 4 clocks");
    end
  endtask

  task automatic drive(logic [11:0] rgb, bit act, bit hs, bit vs, logic [1:0] md);
    bus.rgb_in    = rgb;
    bus.active_in = act;
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    bus.mode      = md;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(12'hFFF, 1'b1, 1'b1, 1'b1, 2'b11);
    bus.audio_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.uo_out !== 8'h00 || bus.pixel_en !== 1'b0 || bus.audio_pwm !== 1'b0) begin
        errors++;
        $display("FAIL reset_state uo=%h pe=%b pwm=%b required uo=00 pe=0 pwm=0",
                 bus.uo_out, bus.pixel_en, bus.audio_pwm);
      end
    end
  endtask

  task automatic test_cadence();
    drive(12'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    bus.audio_in = 8'h00;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (bus.pixel_en !== 1'(i % 2) || bus.pixel_en !== m_pe) begin
        errors++;
        $display("FAIL cadence cycle=%0d pe=%b required %0d", i, bus.pixel_en, i % 2);
      end
      checks++;
      if (bus.uo_out !== 8'h00) begin
        errors++;
        $display("FAIL cadence_uo cycle=%0d uo=%h required 00", i, bus.uo_out);
      end
    end
  endtask

  task automatic test_passthrough();
    drive(12'hF84, 1'b1, 1'b1, 1'b0, 2'b00);
    pixel();
    checks++;
    if (bus.uo_out !== 8'hD3 || bus.uo_out !== m_uo) begin
      errors++;
      $display("FAIL passthrough uo=%h required d3 (model %h)", bus.uo_out, m_uo);
    end
    drive(12'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    checks++;
    if (bus.uo_out !== 8'hD3 || bus.pixel_en !== 1'b1) begin
      errors++;
      $display("FAIL passthrough_hold uo=%h pe=%b required d3 pe=1", bus.uo_out, bus.pixel_en);
    end
  endtask

  task automatic test_blank_polarity();
    drive(12'hFFF, 1'b0, 1'b0, 1'b1, 2'b10);
    pixel();
    checks++;
    if (bus.uo_out !== 8'h80 || bus.uo_out !== m_uo) begin
      errors++;
      $display("FAIL blank_polarity uo=%h required 80 (model %h)", bus.uo_out, m_uo);
    end
  endtask

  task automatic test_dither_line0();
    logic [7:0] exp_uo[4] = '{8'h07, 8'h70, 8'h07, 8'h70};  // channel values 2,1,2,1
    drive(12'h000, 1'b0, 1'b0, 1'b1, 2'b01);
    pixel();
    for (int i = 0; i < 4; i++) begin
      drive(12'h666, 1'b1, 1'b0, 1'b0, 2'b01);
      pixel();
      checks++;
      if (bus.uo_out !== exp_uo[i] || bus.uo_out !== m_uo) begin
        errors++;
        $display("FAIL dither_y0 px=%0d uo=%h required %h", i, bus.uo_out, exp_uo[i]);
      end
    end
  endtask

  task automatic test_dither_y();
    logic [7:0] exp_uo[4] = '{8'h70, 8'h07, 8'h70, 8'h07};  // channel values 1,2,1,2
    drive(12'h000, 1'b0, 1'b0, 1'b0, 2'b01);
    pixel();  // end of line 0 -> y=1
    for (int i = 0; i < 4; i++) begin
      drive(12'h666, 1'b1, 1'b0, 1'b0, 2'b01);
      pixel();
      checks++;
      if (bus.uo_out !== exp_uo[i] || bus.uo_out !== m_uo) begin
        errors++;
        $display("FAIL dither_y1 px=%0d uo=%h required %h", i, bus.uo_out, exp_uo[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(12'hFFF, 1'b1, 1'b0, 1'b0, 2'b01);
      pixel();
      checks++;
      if (bus.uo_out !== 8'h77) begin
        errors++;
        $display("FAIL dither_sat px=%0d uo=%h required 77", i, bus.uo_out);
      end
    end
    drive(12'h000, 1'b0, 1'b0, 1'b1, 2'b01);
    pixel();  // vsync -> y=0
    drive(12'h666, 1'b1, 1'b0, 1'b0, 2'b01);
    pixel();
    checks++;
    if (bus.uo_out !== 8'h07) begin
      errors++;
      $display("FAIL dither_vsync uo=%h required 07", bus.uo_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(12'($urandom), ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(15) == 0),
            2'($urandom));
      bus.audio_in = 8'($urandom);
      step();
      checks++;
      if (bus.uo_out !== m_uo || bus.pixel_en !== m_pe || bus.audio_pwm !== m_pwm) begin
        errors++;
        $display("FAIL random cyc=%0d uo=%h pe=%b pwm=%b required uo=%h pe=%b pwm=%b",
                 i, bus.uo_out, bus.pixel_en, bus.audio_pwm, m_uo, m_pe, m_pwm);
      end
    end
  endtask

  task automatic test_audio();
    logic [7:0] vals[5];
    int highs;
    vals = '{8'h40, 8'h00, 8'hFF, 8'h01, 8'($urandom)};
    for (int v = 0; v < 5; v++) begin
      bus.audio_in = vals[v];
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (bus.audio_pwm === 1'b1) highs++;
        if (bus.audio_pwm !== m_pwm) begin
          checks++;
          errors++;
          $display("FAIL audio_bit val=%h clk=%0d pwm=%b required %b", vals[v], i,
                   bus.audio_pwm, m_pwm);
        end
      end
      checks++;
      if (highs != int'(vals[v])) begin
        errors++;
        $display("FAIL audio_density val=%h highs=%0d required %0d", vals[v], highs, vals[v]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bus.audio_in = 8'hFF;
    drive(12'hFFF, 1'b1, 1'b1, 1'b0, 2'b00);
    pixel();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (bus.audio_pwm !== 1'b0 || bus.uo_out !== 8'h00 || bus.pixel_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun pwm=%b uo=%h pe=%b required 0/00/0",
               bus.audio_pwm, bus.uo_out, bus.pixel_en);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.pixel_en !== 1'(i % 2)) begin
        errors++;
        $display("FAIL reset_cadence cycle=%0d pe=%b required %0d", i, bus.pixel_en, i % 2);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(12'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    bus.audio_in = 8'h00;
    m_ph = 0; m_pe = 0; m_x = 0; m_y = 0; m_pact = 0; m_uo = 8'h00; m_acc = 0; m_pwm = 0;
    #1;
    test_reset();
    test_cadence();
    test_passthrough();
    test_blank_polarity();
    test_dither_line0();
    test_dither_y();
    test_random();
    test_audio();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
